// File: rtl/acsp_trig_pkg.sv
// Shared types and config-word layout for the staged trigger.
package acsp_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } trig_state_e;

  typedef struct packed {
    logic [15:0] delay;
    logic [1:0]  level;
    logic [4:0]  channel;
    logic        serial;
    logic        start;
  } stage_cfg_t;

  localparam int CFG_DELAY_LSB  = 0;
  localparam int CFG_DELAY_MSB  = 15;
  localparam int CFG_LEVEL_LSB  = 16;
  localparam int CFG_LEVEL_MSB  = 17;
  localparam int CFG_CHAN_LSB   = 20;
  localparam int CFG_CHAN_MSB   = 24;
  localparam int CFG_SERIAL_BIT = 26;
  localparam int CFG_START_BIT  = 27;

  localparam logic [1:0] TRIG_LEVEL_MAX = 2'd3;

  function automatic stage_cfg_t decode_cfg(input logic [31:0] word);
    stage_cfg_t c;
    c.delay   = word[CFG_DELAY_MSB:CFG_DELAY_LSB];
    c.level   = word[CFG_LEVEL_MSB:CFG_LEVEL_LSB];
    c.channel = word[CFG_CHAN_MSB:CFG_CHAN_LSB];
    c.serial  = word[CFG_SERIAL_BIT];
    c.start   = word[CFG_START_BIT];
    return c;
  endfunction

endpackage

// File: rtl/trig_stage.sv
// One trigger stage: mask/value/config registers and the match comparator.
// Serial history is compiled in only when TRIG_SERIAL_EN is defined.
module trig_stage #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_mask,
  input  logic                    wr_value,
  input  logic                    wr_config,
  input  logic [31:0]             cfg_data,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    hist_clear,
  output logic                    match,
  output logic [1:0]              level,
  output logic                    start,
  output logic [DELAY_WIDTH-1:0]  delay
);
  import acsp_trig_pkg::*;

  logic [SAMPLE_WIDTH-1:0] mask_r;
  logic [SAMPLE_WIDTH-1:0] value_r;
  stage_cfg_t              cfg_r;
  logic [SAMPLE_WIDTH-1:0] sample_s;
  logic                    unused_s;

  // Stage register file; strobes arrive already qualified and one-hot.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_r  <= '0;
      value_r <= '0;
      cfg_r   <= '0;
    end else begin
      if (wr_config) cfg_r   <= decode_cfg(cfg_data);
      if (wr_value)  value_r <= cfg_data[SAMPLE_WIDTH-1:0];
      if (wr_mask)   mask_r  <= cfg_data[SAMPLE_WIDTH-1:0];
    end
  end

`ifdef TRIG_SERIAL_EN
  logic [SAMPLE_WIDTH-1:0] hist_r;
  logic [SAMPLE_WIDTH-1:0] hist_next_s;
  logic                    chan_bit_s;

  // Select the configured channel and form the history including this bit.
  always_comb begin
    chan_bit_s = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      chan_bit_s = (cfg_r.channel == 5'(i)) ? dataIn[i] : chan_bit_s;
    end
    hist_next_s = SAMPLE_WIDTH'({hist_r, chan_bit_s});
    sample_s    = cfg_r.serial ? hist_next_s : dataIn;
  end

  // History shift register, newest bit at bit 0.
  always_ff @(posedge clock) begin
    if (reset || hist_clear) begin
      hist_r <= '0;
    end else if (valid) begin
      hist_r <= hist_next_s;
    end
  end

  assign unused_s = ^{cfg_data, cfg_r.delay};
`else
  assign sample_s = dataIn;
  assign unused_s = ^{cfg_data, cfg_r, hist_clear};
`endif

  assign match = valid && (((sample_s ^ value_r) & mask_r) == {SAMPLE_WIDTH{1'b0}});
  assign level = cfg_r.level;
  assign start = cfg_r.start;
  assign delay = cfg_r.delay[DELAY_WIDTH-1:0];

endmodule

// File: rtl/trigger_staged.sv
// Multi-stage logic-analyser trigger: level-sequenced matches, post-match delay, run.
// Optional serial match mode is enabled with the TRIG_SERIAL_EN macro.
module trigger_staged #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    load_mask,
  input  logic                    load_value,
  input  logic                    load_config,
  input  logic [1:0]              stage_sel,
  input  logic [31:0]             cfg_data,
  output logic                    run,
  output logic [1:0]              trig_level,
  output logic                    armed
);
  import acsp_trig_pkg::*;

  trig_state_e            state_r, state_next_s;
  logic [1:0]             level_r, level_next_s;
  logic [DELAY_WIDTH-1:0] cnt_r, cnt_next_s;
  logic                   run_r, armed_r;

  logic                   wr_ok_s;
  logic                   hist_clear_s;
  logic                   match_s [NUM_STAGES];
  logic [1:0]             level_s [NUM_STAGES];
  logic                   start_s [NUM_STAGES];
  logic [DELAY_WIDTH-1:0] delay_s [NUM_STAGES];

  logic                   start_hit_s;
  logic                   adv_hit_s;
  logic [DELAY_WIDTH-1:0] start_delay_s;

  assign wr_ok_s      = (state_r == ST_IDLE) && (32'(stage_sel) < 32'(NUM_STAGES));
  assign hist_clear_s = (state_r == ST_IDLE) || (state_next_s == ST_IDLE);

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic sel_s;
    assign sel_s = wr_ok_s && (stage_sel == 2'(g));

    trig_stage #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .DELAY_WIDTH (DELAY_WIDTH)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .wr_mask   (sel_s && load_mask && !load_value && !load_config),
      .wr_value  (sel_s && load_value && !load_config),
      .wr_config (sel_s && load_config),
      .cfg_data  (cfg_data),
      .valid     (valid),
      .dataIn    (dataIn),
      .hist_clear(hist_clear_s),
      .match     (match_s[g]),
      .level     (level_s[g]),
      .start     (start_s[g]),
      .delay     (delay_s[g])
    );
  end

  // Reduce stage hits at the current level; lowest-index start stage supplies the delay.
  always_comb begin
    logic hit_v;
    hit_v         = 1'b0;
    start_hit_s   = 1'b0;
    adv_hit_s     = 1'b0;
    start_delay_s = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      hit_v         = match_s[i] && (level_s[i] == level_r);
      start_hit_s   = start_hit_s | (hit_v & start_s[i]);
      adv_hit_s     = adv_hit_s | (hit_v & !start_s[i]);
      start_delay_s = (hit_v && start_s[i]) ? delay_s[i] : start_delay_s;
    end
  end

  // Next-state, level and delay-counter logic.
  always_comb begin
    state_next_s = state_r;
    level_next_s = level_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_next_s = ST_IDLE;
        end else if (start_hit_s) begin
          // A zero delay skips DELAY so run rises on the edge ending the match cycle.
          state_next_s = (start_delay_s == '0) ? ST_RUN : ST_DELAY;
          cnt_next_s   = start_delay_s;
        end else if (adv_hit_s) begin
          level_next_s = (level_r == TRIG_LEVEL_MAX) ? level_r : level_r + 2'd1;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_DELAY: begin
        if (!arm) begin
          state_next_s = ST_IDLE;
        end else if (valid) begin
          if (cnt_r <= DELAY_WIDTH'(1)) begin
            state_next_s = ST_RUN;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s   = cnt_r - DELAY_WIDTH'(1);
          end
        end else begin
          state_next_s = ST_DELAY;
        end
      end
      ST_RUN: begin
        if (!arm) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (state_next_s == ST_IDLE) begin
      level_next_s = 2'd0;
      cnt_next_s   = '0;
    end else begin
      level_next_s = level_next_s;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      level_r <= 2'd0;
      cnt_r   <= '0;
      run_r   <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      level_r <= level_next_s;
      cnt_r   <= cnt_next_s;
      run_r   <= (state_next_s == ST_RUN);
      armed_r <= (state_next_s == ST_ARMED) || (state_next_s == ST_DELAY);
    end
  end

  assign run        = run_r;
  assign trig_level = level_r;
  assign armed      = armed_r;

endmodule
